ic_miss_queue: RTL and testbench

// - Parametrised miss-status/fill tracker between the icache controller and the memory controller.
// - Holds up to NXID outstanding line misses, one per transaction ID.
// - Issues line reads, accepts out-of-order responses by xid and emits one-cycle fill writes.
// - Fill writes carry data, tag and way, for the data/tag RAM write ports.
// - Merges duplicate misses to a line already pending; supports flush of in-flight fills.

---
 rtl/ic_pkg.sv | 24 ++
 rtl/ic_mq_entry.sv | 72 +++++++
 rtl/ic_miss_queue.sv | 152 +++++++++++++++
 tb/tb_ic_miss_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared types for the icache miss queue: entry state, entry record, xid.
package ic_pkg;

    localparam int NXID       = 4;
    localparam int IC_XID_W   = $clog2(NXID);
    localparam int IC_ADDR_W  = 23;
    localparam int IC_WAY_W   = 2;

    typedef logic [IC_XID_W-1:0] ic_xid_t;

    typedef enum logic [1:0] {
        FREE,
        ALLOC,
        ISSUED
    } ic_mq_state_e;

    typedef struct packed {
        ic_mq_state_e         state;
        logic [IC_ADDR_W-1:0] addr;
        logic [IC_WAY_W-1:0]  way;
        logic                 discard;
    } ic_mq_entry_t;

endpackage

// File: rtl/ic_mq_entry.sv
// One miss tracker entry: FREE -> ALLOC -> ISSUED -> FREE, plus line compare.
module ic_mq_entry
    import ic_pkg::*;
#(
    parameter int AW    = 23,
    parameter int WAY_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_alloc,
    input  logic             i_issue,
    input  logic             i_resp,
    input  logic             i_flush,
    input  logic [AW-1:0]    i_addr,
    input  logic [WAY_W-1:0] i_way,
    output ic_mq_state_e     o_state,
    output logic [AW-1:0]    o_addr,
    output logic [WAY_W-1:0] o_way,
    output logic             o_discard,
    output logic             o_match
);

    ic_mq_state_e     r_state;
    logic [AW-1:0]    r_addr;
    logic [WAY_W-1:0] r_way;
    logic             r_discard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FREE;
            r_addr    <= '0;
            r_way     <= '0;
            r_discard <= 1'b0;
        end else begin
            unique case (r_state)
                FREE: begin
                    if (i_alloc) begin
                        r_state   <= ALLOC;
                        r_addr    <= i_addr;
                        r_way     <= i_way;
                        r_discard <= 1'b0;
                    end
                end
                ALLOC: begin
                    // a request already handed to memory must still see its response
                    if (i_issue) begin
                        r_state   <= ISSUED;
                        r_discard <= i_flush;
                    end else if (i_flush) begin
                        r_state <= FREE;
                    end
                end
                ISSUED: begin
                    if (i_resp) begin
                        r_state   <= FREE;
                        r_discard <= 1'b0;
                    end else if (i_flush) begin
                        r_discard <= 1'b1;
                    end
                end
                default: r_state <= FREE;
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_addr    = r_addr;
    assign o_way     = r_way;
    assign o_discard = r_discard;
    assign o_match   = (r_state != FREE) && !r_discard && (r_addr == i_addr);

endmodule

// File: rtl/ic_miss_queue.sv
// Icache miss/fill tracker: allocates per-xid entries, issues line reads,
// merges duplicate misses and turns out-of-order responses into fill writes.
module ic_miss_queue
    import ic_pkg::*;
#(
    parameter int NXID      = ic_pkg::NXID,
    parameter int XID_W     = $clog2(NXID),
    parameter int ADDR_HI   = 26,
    parameter int ADDR_LO   = 4,
    parameter int LINE_BITS = 128,
    parameter int WAYS      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [ADDR_HI:ADDR_LO]     miss_addr,
    input  logic [$clog2(WAYS)-1:0]    miss_way,
    output logic                       miss_merged,
    input  logic                       flush,
    output logic [ADDR_HI:ADDR_LO]     ic_mem_addr,
    output logic [XID_W-1:0]           ic_mem_xid,
    output logic                       ic_mem_re,
    input  logic                       mem_ic_ready,
    input  logic                       mem_ic_valid,
    input  logic [XID_W-1:0]           mem_ic_xid,
    input  logic [LINE_BITS-1:0]       mem_ic_data,
    output logic                       fill_valid,
    output logic [ADDR_HI:ADDR_LO]     fill_addr,
    output logic [$clog2(WAYS)-1:0]    fill_way,
    output logic [LINE_BITS-1:0]       fill_data,
    output logic                       busy,
    output logic [XID_W:0]             pending_cnt,
    output logic                       xid_err
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int AW    = ADDR_HI - ADDR_LO + 1;

    logic [ADDR_HI:ADDR_LO] w_addr  [NXID];
    logic [WAY_W-1:0]       w_way   [NXID];
    ic_mq_state_e           w_state [NXID];
    logic [NXID-1:0]        w_disc, w_match, w_alloc, w_issue, w_resp;
    logic                   w_any_free, w_any_alloc;
    logic                   w_accept, w_merge, w_re, w_resp_hit;
    logic [XID_W-1:0]       w_free_idx, w_alloc_idx, w_sel;
    logic [XID_W:0]         w_cnt;

    logic                   r_lock;
    logic [XID_W-1:0]       r_lock_xid;
    logic                   r_merged, r_xid_err, r_fill_valid;
    logic [ADDR_HI:ADDR_LO] r_fill_addr;
    logic [WAY_W-1:0]       r_fill_way;
    logic [LINE_BITS-1:0]   r_fill_data;

    for (genvar g = 0; g < NXID; g++) begin : g_ent
        ic_mq_entry #(.AW(AW), .WAY_W(WAY_W)) u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_alloc   (w_alloc[g]),
            .i_issue   (w_issue[g]),
            .i_resp    (w_resp[g]),
            .i_flush   (flush),
            .i_addr    (miss_addr),
            .i_way     (miss_way),
            .o_state   (w_state[g]),
            .o_addr    (w_addr[g]),
            .o_way     (w_way[g]),
            .o_discard (w_disc[g]),
            .o_match   (w_match[g])
        );
    end

    // downward scan leaves the lowest matching index selected
    always_comb begin
        w_any_free  = 1'b0;
        w_any_alloc = 1'b0;
        w_free_idx  = '0;
        w_alloc_idx = '0;
        w_cnt       = '0;
        for (int i = NXID - 1; i >= 0; i--) begin
            if (w_state[i] == FREE) begin
                w_any_free = 1'b1;
                w_free_idx = XID_W'(i);
            end
            if (w_state[i] == ALLOC) begin
                w_any_alloc = 1'b1;
                w_alloc_idx = XID_W'(i);
            end
            if (w_state[i] != FREE) begin
                w_cnt = w_cnt + (XID_W + 1)'(1);
            end
        end
    end

    assign miss_ready = w_any_free && !flush;
    assign w_accept   = miss_valid && miss_ready;
    assign w_merge    = w_accept && (|w_match);
    assign w_re       = w_any_alloc;
    assign w_sel      = r_lock ? r_lock_xid : w_alloc_idx;
    assign w_resp_hit = mem_ic_valid && (w_state[mem_ic_xid] == ISSUED);

    always_comb begin
        w_alloc = '0;
        w_issue = '0;
        w_resp  = '0;
        for (int i = 0; i < NXID; i++) begin
            w_alloc[i] = w_accept && !w_merge && (w_free_idx == XID_W'(i));
            w_issue[i] = w_re && mem_ic_ready && (w_sel == XID_W'(i));
            w_resp[i]  = w_resp_hit && (mem_ic_xid == XID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock       <= 1'b0;
            r_lock_xid   <= '0;
            r_merged     <= 1'b0;
            r_xid_err    <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_way   <= '0;
            r_fill_data  <= '0;
        end else begin
            r_merged     <= w_merge;
            r_lock       <= w_re && !mem_ic_ready && !flush;
            r_lock_xid   <= w_sel;
            r_fill_valid <= w_resp_hit && !w_disc[mem_ic_xid] && !flush;
            if (mem_ic_valid && !w_resp_hit) begin
                r_xid_err <= 1'b1;
            end
            if (w_resp_hit) begin
                r_fill_addr <= w_addr[mem_ic_xid];
                r_fill_way  <= w_way[mem_ic_xid];
                r_fill_data <= mem_ic_data;
            end
        end
    end

    assign ic_mem_re   = w_re;
    assign ic_mem_xid  = w_re ? w_sel : '0;
    assign ic_mem_addr = w_re ? w_addr[w_sel] : '0;
    assign miss_merged = r_merged;
    assign fill_valid  = r_fill_valid;
    assign fill_addr   = r_fill_addr;
    assign fill_way    = r_fill_way;
    assign fill_data   = r_fill_data;
    assign busy        = (w_cnt != '0);
    assign pending_cnt = w_cnt;
    assign xid_err     = r_xid_err;

endmodule

// File: tb/tb_ic_miss_queue.sv
// Directed bench for ic_miss_queue: hand-computed vectors checked by immediate assertions.
module tb_ic_miss_queue;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_valid = 1'b0;
    logic         miss_ready;
    logic [26:4]  miss_addr = '0;
    logic [1:0]   miss_way = '0;
    logic         miss_merged;
    logic         flush = 1'b0;
    logic [26:4]  ic_mem_addr;
    logic [1:0]   ic_mem_xid;
    logic         ic_mem_re;
    logic         mem_ic_ready = 1'b0;
    logic         mem_ic_valid = 1'b0;
    logic [1:0]   mem_ic_xid = '0;
    logic [127:0] mem_ic_data = '0;
    logic         fill_valid;
    logic [26:4]  fill_addr;
    logic [1:0]   fill_way;
    logic [127:0] fill_data;
    logic         busy;
    logic [2:0]   pending_cnt;
    logic         xid_err;

    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;
    int hs0;

    ic_miss_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_addr    (miss_addr),
        .miss_way     (miss_way),
        .miss_merged  (miss_merged),
        .flush        (flush),
        .ic_mem_addr  (ic_mem_addr),
        .ic_mem_xid   (ic_mem_xid),
        .ic_mem_re    (ic_mem_re),
        .mem_ic_ready (mem_ic_ready),
        .mem_ic_valid (mem_ic_valid),
        .mem_ic_xid   (mem_ic_xid),
        .mem_ic_data  (mem_ic_data),
        .fill_valid   (fill_valid),
        .fill_addr    (fill_addr),
        .fill_way     (fill_way),
        .fill_data    (fill_data),
        .busy         (busy),
        .pending_cnt  (pending_cnt),
        .xid_err      (xid_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && ic_mem_re && mem_ic_ready) n_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic miss(input logic [26:4] a, input logic [1:0] w);
        miss_valid = 1'b1;
        miss_addr  = a;
        miss_way   = w;
    endtask

    task automatic resp(input logic [1:0] x, input logic [127:0] d);
        mem_ic_valid = 1'b1;
        mem_ic_xid   = x;
        mem_ic_data  = d;
    endtask

    // fill bundle: {valid, addr, way}
    function automatic logic [25:0] fb(input logic v, input logic [22:0] a,
                                       input logic [1:0] w);
        return {v, a, w};
    endfunction

    initial begin
        // reset state
        #23;
        chk("rst_ready", miss_ready, 1'b1);
        chk("rst_idle", {busy, pending_cnt, ic_mem_re, fill_valid, xid_err, miss_merged}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single miss
        mem_ic_ready = 1'b1;
        miss(23'h12345, 2'd2);
        tick();
        miss_valid = 1'b0;
        chk("t1_req", {ic_mem_re, ic_mem_xid, ic_mem_addr}, {1'b1, 2'd0, 23'h12345});
        chk("t1_cnt", pending_cnt, 3'd1);
        tick();
        chk("t1_issued", {ic_mem_re, busy}, 2'b01);
        resp(2'd0, 128'h0123456789abcdeffedcba9876543210);
        tick();
        mem_ic_valid = 1'b0;
        chk("t1_fill", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h12345, 2'd2));
        chk("t1_data", fill_data, 128'h0123456789abcdeffedcba9876543210);
        chk("t1_free", pending_cnt, 3'd0);
        tick();
        chk("t1_pulse", fill_valid, 1'b0);

        // four misses back to back, out-of-order responses
        miss(23'h00100, 2'd0);
        tick();
        miss(23'h00200, 2'd1);
        tick();
        miss(23'h00300, 2'd2);
        tick();
        miss(23'h00400, 2'd3);
        tick();
        chk("t2_full", {miss_ready, pending_cnt}, {1'b0, 3'd4});
        miss_valid = 1'b0;
        tick();
        chk("t2_full2", {miss_ready, ic_mem_re}, 2'b00);
        resp(2'd3, 128'h33);
        tick();
        chk("t2_fill3", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h00400, 2'd3));
        chk("t2_ready", {miss_ready, pending_cnt}, {1'b1, 3'd3});
        resp(2'd1, 128'h11);
        tick();
        chk("t2_fill1", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h00200, 2'd1));
        resp(2'd0, 128'h00);
        tick();
        chk("t2_fill0", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h00100, 2'd0));
        resp(2'd2, 128'h22);
        tick();
        mem_ic_valid = 1'b0;
        chk("t2_fill2", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h00300, 2'd2));
        chk("t2_data2", fill_data, 128'h22);
        chk("t2_empty", pending_cnt, 3'd0);

        // duplicate miss merges
        miss(23'h00555, 2'd1);
        tick();
        hs0 = n_hs;
        miss(23'h00555, 2'd3);
        tick();
        miss_valid = 1'b0;
        chk("t3_merged", {miss_merged, pending_cnt}, {1'b1, 3'd1});
        tick();
        chk("t3_one_req", {miss_merged, ic_mem_re, 32'(n_hs - hs0)}, {2'b00, 32'd1});
        resp(2'd0, 128'h55);
        tick();
        mem_ic_valid = 1'b0;
        chk("t3_fill", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h00555, 2'd1));

        // memory stalls for five cycles
        mem_ic_ready = 1'b0;
        miss(23'h00777, 2'd0);
        tick();
        hs0 = n_hs;
        miss(23'h00888, 2'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stable", {ic_mem_re, ic_mem_xid, ic_mem_addr}, {1'b1, 2'd0, 23'h00777});
            tick();
            miss_valid = 1'b0;
        end
        chk("t4_cnt", {pending_cnt, 32'(n_hs - hs0)}, {3'd2, 32'd0});
        mem_ic_ready = 1'b1;
        tick();
        chk("t4_next", {ic_mem_re, ic_mem_xid, ic_mem_addr}, {1'b1, 2'd1, 23'h00888});
        tick();
        chk("t4_done", {ic_mem_re, 32'(n_hs - hs0)}, {1'b0, 32'd2});
        resp(2'd1, 128'h88);
        tick();
        chk("t4_fill1", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h00888, 2'd1));
        resp(2'd0, 128'h77);
        tick();
        mem_ic_valid = 1'b0;
        chk("t4_fill0", fb(fill_valid, fill_addr, fill_way), fb(1'b1, 23'h00777, 2'd0));

        // flush with one ALLOC and two ISSUED entries
        miss(23'h00a00, 2'd0);
        tick();
        miss(23'h00b00, 2'd1);
        tick();
        miss(23'h00c00, 2'd2);
        tick();
        mem_ic_ready = 1'b0;
        miss_valid   = 1'b0;
        chk("t5_pre", {ic_mem_re, ic_mem_xid, pending_cnt}, {1'b1, 2'd2, 3'd3});
        flush = 1'b1;
        miss(23'h00d00, 2'd3);
        #1;
        chk("t5_flush_rdy", miss_ready, 1'b0);
        tick();
        flush      = 1'b0;
        miss_valid = 1'b0;
        chk("t5_post", {ic_mem_re, busy, pending_cnt}, {1'b0, 1'b1, 3'd2});
        mem_ic_ready = 1'b1;
        hs0 = n_hs;
        tick();
        tick();
        chk("t5_no_issue", 32'(n_hs - hs0), 32'd0);
        resp(2'd1, 128'hbb);
        tick();
        chk("t5_disc1", {fill_valid, pending_cnt}, {1'b0, 3'd1});
        resp(2'd0, 128'haa);
        tick();
        mem_ic_valid = 1'b0;
        chk("t5_disc0", {fill_valid, busy}, 2'b00);

        // flush on the same cycle as a response suppresses the fill
        miss(23'h00e00, 2'd2);
        tick();
        miss_valid = 1'b0;
        tick();
        resp(2'd0, 128'hee);
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        mem_ic_valid = 1'b0;
        chk("t5_sup", {fill_valid, pending_cnt, xid_err}, {1'b0, 3'd0, 1'b0});

        // response to a FREE entry
        resp(2'd3, 128'hff);
        tick();
        mem_ic_valid = 1'b0;
        chk("t6_err", {fill_valid, xid_err}, 2'b01);
        tick();
        chk("t6_sticky", xid_err, 1'b1);

        // async reset mid-traffic
        mem_ic_ready = 1'b0;
        miss(23'h00f00, 2'd1);
        tick();
        miss_valid = 1'b0;
        chk("t6_pend", {pending_cnt, ic_mem_re}, {3'd1, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst", {busy, pending_cnt, ic_mem_re, xid_err, fill_valid}, '0);
        chk("t6_rst_rdy", miss_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
